// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter onto one shared memory bus.
// Each port may hold one pending request. In IDLE, or in the same cycle as a
// completion, a candidate is issued on mem_in with no added latency. Each
// completion's response is passed straight through to the port that owns the
// transaction.
//
// Ports:
//   clk, rst  - clock; asynchronous active-high reset
//   imem_in   - instruction-port request (single-cycle mem_valid pulse)
//   imem_out  - instruction-port response
//   dmem_in   - data-port request
//   dmem_out  - data-port response
//   mem_in    - shared memory request
//   mem_out   - shared memory response (mem_ready or mem_error completes)
// Parameter:
//   data_priority - 1: data port wins ties; 0: round-robin on ties

package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned MODE_W = 2;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_fence;
    logic              mem_spec;
    logic              mem_instr;
    logic [MODE_W-1:0] mem_mode;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_error;
    logic              mem_ready;
  } mem_out_type;

endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit data_priority = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t     state_q, state_d;
  // Pending registers; the mem_valid bit of each doubles as the pending flag.
  mem_in_type ipend_q, ipend_d;
  mem_in_type dpend_q, dpend_d;
  // Last issued payload, held on mem_in while a transaction is outstanding.
  mem_in_type issued_q, issued_d;
  // Port granted last: 0 = instruction, 1 = data.
  logic       last_q, last_d;

  logic       completion;
  logic       i_cand, d_cand;
  logic       grant_d;
  mem_in_type i_req, d_req;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ipend_q  <= '0;
      dpend_q  <= '0;
      issued_q <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ipend_q  <= ipend_d;
      dpend_q  <= dpend_d;
      issued_q <= issued_d;
      last_q   <= last_d;
    end
  end

  // Next-state, grant and output steering
  always_comb begin
    state_d  = state_q;
    ipend_d  = ipend_q;
    dpend_d  = dpend_q;
    issued_d = issued_q;
    last_d   = last_q;
    mem_in   = issued_q;
    mem_in.mem_valid = 1'b0;
    imem_out = '0;
    dmem_out = '0;
    grant_d  = 1'b0;

    // Responses only count while a transaction is outstanding.
    completion = (state_q != IDLE) && (mem_out.mem_ready || mem_out.mem_error);

    // A same-cycle request supersedes the port's pending entry.
    i_cand = imem_in.mem_valid || ipend_q.mem_valid;
    d_cand = dmem_in.mem_valid || dpend_q.mem_valid;
    i_req  = imem_in.mem_valid ? imem_in : ipend_q;
    d_req  = dmem_in.mem_valid ? dmem_in : dpend_q;

    if (completion) begin
      if (state_q == IBUSY) begin
        imem_out = mem_out;
      end else begin
        dmem_out = mem_out;
      end
      state_d = IDLE;
    end

    // Newest request on a port always lands in its pending register.
    if (imem_in.mem_valid) begin
      ipend_d = imem_in;
    end
    if (dmem_in.mem_valid) begin
      dpend_d = dmem_in;
    end

    // Issue from IDLE, or back-to-back in the completion cycle.
    if (((state_q == IDLE) || completion) && (i_cand || d_cand)) begin
      if (i_cand && d_cand) begin
        grant_d = data_priority ? 1'b1 : ~last_q;
      end else begin
        grant_d = d_cand;
      end
      if (grant_d) begin
        mem_in   = d_req;
        issued_d = d_req;
        dpend_d.mem_valid = 1'b0;
        state_d  = DBUSY;
      end else begin
        mem_in   = i_req;
        issued_d = i_req;
        ipend_d.mem_valid = 1'b0;
        state_d  = IBUSY;
      end
      mem_in.mem_valid = 1'b1;
      last_d = grant_d;
    end

    // Outputs are forced quiet for the whole time reset is asserted.
    if (rst) begin
      mem_in   = '0;
      imem_out = '0;
      dmem_out = '0;
    end
  end

endmodule
